// File: rtl/riscv_32_pkg.sv
// Shared opcode constants, control FSM states and next-PC select encoding
// for the 32-bit pipeline control slice.
package riscv_32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_DIV_WAIT = 1'b1
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BR_JAL = 2'b01,
        PC_JALR   = 2'b10
    } pc_sel_e;

    // DIV/DIVU/REM/REMU are the M-extension ops with funct3[2] set.
    function automatic logic is_div_op(input logic [6:0] opcode,
                                       input logic       funct3_msb,
                                       input logic [6:0] funct7);
        return (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV) && funct3_msb;
    endfunction

endpackage

// File: rtl/riscv_32_hazard_unit.sv
// Combinational register-write classification and WB->EX forwarding compare.
module riscv_32_hazard_unit
    import riscv_32_pkg::*;
(
    input  logic [6:0] ex_opcode,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_valid,
    input  logic       wb_we,
    input  logic [4:0] wb_rd,
    output logic       regwrite,
    output logic       fwd_a,
    output logic       fwd_b
);

    logic wb_live;

    always_comb begin
        regwrite = 1'b0;
        if (ex_rd != 5'd0) begin
            regwrite = ex_opcode inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                                         OPC_JAL, OPC_JALR, OPC_SYSTEM};
        end
    end

    // x0 is never forwarded even if some writer targeted it.
    assign wb_live = ex_valid && wb_we && (wb_rd != 5'd0);
    assign fwd_a   = wb_live && (wb_rd == ex_rs1);
    assign fwd_b   = wb_live && (wb_rd == ex_rs2);

endmodule

// File: rtl/riscv_32_pipe_ctrl.sv
// Pipeline control: multi-cycle divide stall FSM, branch/jump redirect,
// EX valid and WB write-back registers.
module riscv_32_pipe_ctrl
    import riscv_32_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_valid,
    input  logic [6:0] ex_opcode,
    input  logic [2:0] ex_funct3,
    input  logic [6:0] ex_funct7,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_br_cond,
    output logic       ex_valid,
    output logic       stall,
    output logic       flush,
    output logic [1:0] pc_sel,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       wb_we,
    output logic [4:0] wb_rd,
    output logic       div_start,
    output logic       div_busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ex_valid_q, ex_valid_d;
    logic wb_we_q, wb_we_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic div_busy_q, div_busy_d;

    logic ex_is_div;
    logic regwrite;
    pc_sel_e pc_sel_n;
    logic unused_funct3;

    assign unused_funct3 = ^ex_funct3[1:0];
    assign ex_is_div     = is_div_op(ex_opcode, ex_funct3[2], ex_funct7);

    riscv_32_hazard_unit u_hazard (
        .ex_opcode (ex_opcode),
        .ex_rs1    (ex_rs1),
        .ex_rs2    (ex_rs2),
        .ex_rd     (ex_rd),
        .ex_valid  (ex_valid_q),
        .wb_we     (wb_we_q),
        .wb_rd     (wb_rd_q),
        .regwrite  (regwrite),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    // The launch cycle stalls too, so a divide stalls EX for DIV_CYCLES cycles in total.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_busy_d = div_busy_q;
        stall      = 1'b0;
        div_start  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_valid_q && ex_is_div) begin
                    div_start  = 1'b1;
                    stall      = 1'b1;
                    cnt_d      = CNT_W'(DIV_CYCLES - 1);
                    div_busy_d = 1'b1;
                    state_d    = ST_DIV_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                if (cnt_q == '0) begin
                    div_busy_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_sel_n = PC_PLUS4;
        if (ex_valid_q && !stall) begin
            if (((ex_opcode == OPC_BRANCH) && ex_br_cond) || (ex_opcode == OPC_JAL)) begin
                pc_sel_n = PC_BR_JAL;
            end else if (ex_opcode == OPC_JALR) begin
                pc_sel_n = PC_JALR;
            end
        end
    end

    assign flush  = (pc_sel_n != PC_PLUS4);
    assign pc_sel = pc_sel_n;

    always_comb begin
        ex_valid_d = stall ? ex_valid_q : (if_valid && !flush);
        wb_we_d    = stall ? 1'b0 : (ex_valid_q && regwrite);
        wb_rd_d    = stall ? wb_rd_q : ex_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            div_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            div_busy_q <= div_busy_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign div_busy = div_busy_q;

endmodule

// File: tb/tb_riscv_32_pipe_ctrl.sv
// Directed plus randomized bench for riscv_32_pipe_ctrl against a cycle-level
// behavioural model that counts divide stall cycles upward.
module tb_riscv_32_pipe_ctrl;
    import riscv_32_pkg::*;

    localparam int DIV_CYCLES = 32;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       if_valid;
    logic [6:0] ex_opcode;
    logic [2:0] ex_funct3;
    logic [6:0] ex_funct7;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_br_cond;
    logic       ex_valid, stall, flush, fwd_a, fwd_b, wb_we, div_start, div_busy;
    logic [1:0] pc_sel;
    logic [4:0] wb_rd;

    int checks = 0;
    int errors = 0;

    bit       m_ex_valid, m_wb_we, m_busy, m_last_stall;
    logic [4:0] m_wb_rd;
    int       m_done;

    logic       o_ex_valid, o_stall, o_flush, o_fwd_a, o_fwd_b, o_wb_we, o_div_start, o_div_busy;
    logic [1:0] o_pc_sel;
    logic [4:0] o_wb_rd;

    logic [6:0] r_op, r_f7;
    logic [2:0] r_f3;
    logic [4:0] r_rs1, r_rs2, r_rd;
    logic       r_br;

    logic [6:0] opc_pool [10] = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL,
                                  OPC_JALR, OPC_BRANCH, OPC_SYSTEM, OPC_LOAD, OPC_STORE};

    always #5 clk = ~clk;

    riscv_32_pipe_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .ex_opcode  (ex_opcode),
        .ex_funct3  (ex_funct3),
        .ex_funct7  (ex_funct7),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_br_cond (ex_br_cond),
        .ex_valid   (ex_valid),
        .stall      (stall),
        .flush      (flush),
        .pc_sel     (pc_sel),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .div_start  (div_start),
        .div_busy   (div_busy)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit writes_reg(input logic [6:0] op, input logic [4:0] rd);
        bit writer;
        writer = (op == OPC_OP) || (op == OPC_OP_IMM) || (op == OPC_LUI) || (op == OPC_AUIPC) ||
                 (op == OPC_JAL) || (op == OPC_JALR) || (op == OPC_SYSTEM);
        return writer && (rd != 5'd0);
    endfunction

    task automatic model_reset();
        m_ex_valid   = 1'b0;
        m_wb_we      = 1'b0;
        m_wb_rd      = 5'd0;
        m_busy       = 1'b0;
        m_done       = 0;
        m_last_stall = 1'b0;
    endtask

    // One clock cycle: drive, sample mid-cycle, compare with the model, advance the model.
    task automatic apply_stimulus(input bit ifv, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input bit br);
        bit div_op, launch, e_stall, e_fwd_a, e_fwd_b;
        logic [1:0] e_pc_sel;
        if_valid   = ifv;
        ex_opcode  = op;
        ex_funct3  = f3;
        ex_funct7  = f7;
        ex_rs1     = rs1;
        ex_rs2     = rs2;
        ex_rd      = rd;
        ex_br_cond = br;
        #4;
        div_op  = (op == 7'b0110011) && (f7 == 7'b0000001) && f3[2];
        launch  = !m_busy && m_ex_valid && div_op;
        e_stall = launch || (m_busy && (m_done < DIV_CYCLES));
        e_pc_sel = 2'b00;
        if (m_ex_valid && !e_stall) begin
            if ((op == 7'b1100011 && br) || op == 7'b1101111) e_pc_sel = 2'b01;
            else if (op == 7'b1100111)                         e_pc_sel = 2'b10;
        end
        e_fwd_a = m_ex_valid && m_wb_we && (m_wb_rd != 0) && (m_wb_rd == rs1);
        e_fwd_b = m_ex_valid && m_wb_we && (m_wb_rd != 0) && (m_wb_rd == rs2);

        o_ex_valid = ex_valid;  o_stall = stall;    o_flush = flush;  o_pc_sel = pc_sel;
        o_fwd_a = fwd_a;        o_fwd_b = fwd_b;    o_wb_we = wb_we;  o_wb_rd = wb_rd;
        o_div_start = div_start; o_div_busy = div_busy;

        check_output("ex_valid", 32'(o_ex_valid), 32'(m_ex_valid));
        check_output("stall", 32'(o_stall), 32'(e_stall));
        check_output("flush", 32'(o_flush), 32'(e_pc_sel != 2'b00));
        check_output("pc_sel", 32'(o_pc_sel), 32'(e_pc_sel));
        check_output("fwd_a", 32'(o_fwd_a), 32'(e_fwd_a));
        check_output("fwd_b", 32'(o_fwd_b), 32'(e_fwd_b));
        check_output("wb_we", 32'(o_wb_we), 32'(m_wb_we));
        if (m_wb_we) check_output("wb_rd", 32'(o_wb_rd), 32'(m_wb_rd));
        check_output("div_start", 32'(o_div_start), 32'(launch));
        check_output("div_busy", 32'(o_div_busy), 32'(m_busy));

        if (launch) begin
            m_busy = 1'b1;
            m_done = 1;
        end else if (m_busy) begin
            if (m_done < DIV_CYCLES) m_done++;
            else                     m_busy = 1'b0;
        end
        if (!e_stall) begin
            m_wb_we    = m_ex_valid && writes_reg(op, rd);
            m_wb_rd    = rd;
            m_ex_valid = ifv && (e_pc_sel == 2'b00);
        end else begin
            m_wb_we = 1'b0;
        end
        m_last_stall = e_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_random();
        int k;
        r_op  = opc_pool[$urandom_range(0, 9)];
        r_f3  = 3'($urandom);
        k     = $urandom_range(0, 2);
        r_f7  = (k == 0) ? 7'b0000000 : ((k == 1) ? 7'b0100000 : 7'b0000001);
        r_rs1 = 5'($urandom_range(0, 7));
        r_rs2 = 5'($urandom_range(0, 7));
        r_rd  = 5'($urandom_range(0, 7));
        r_br  = 1'($urandom);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int stalls;
        int starts;
        rst_n = 1'b0;
        if_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0; ex_funct7 = '0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_br_cond = 1'b0;
        model_reset();
        #2;
        check_output("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_output("rst_stall", 32'(stall), 32'd0);
        check_output("rst_flush", 32'(flush), 32'd0);
        check_output("rst_pc_sel", 32'(pc_sel), 32'd0);
        check_output("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        check_output("rst_wb", 32'({wb_we, wb_rd}), 32'd0);
        check_output("rst_div", 32'({div_start, div_busy}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset release with a valid fetch, then addi x5 / add x6,x5,x5.
        apply_stimulus(1, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        check_output("rel_ex_valid_before", 32'(o_ex_valid), 32'd0);
        apply_stimulus(1, OPC_OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 0);
        check_output("rel_ex_valid_after", 32'(o_ex_valid), 32'd1);
        apply_stimulus(1, OPC_OP, 3'd0, 7'd0, 5'd5, 5'd5, 5'd6, 0);
        check_output("fwd_x5_a", 32'(o_fwd_a), 32'd1);
        check_output("fwd_x5_b", 32'(o_fwd_b), 32'd1);
        check_output("fwd_x5_rd", 32'(o_wb_rd), 32'd5);
        apply_stimulus(1, OPC_OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        apply_stimulus(1, OPC_OP, 3'd0, 7'd0, 5'd0, 5'd0, 5'd6, 0);
        check_output("fwd_x0_ab", 32'({o_fwd_a, o_fwd_b}), 32'd0);

        // Branch taken, bubble, branch not taken, JAL, bubble, JALR.
        apply_stimulus(1, OPC_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 1);
        check_output("beq_t_pc_sel", 32'(o_pc_sel), 32'd1);
        check_output("beq_t_flush", 32'(o_flush), 32'd1);
        apply_stimulus(1, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        check_output("beq_t_bubble", 32'(o_ex_valid), 32'd0);
        apply_stimulus(1, OPC_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 0);
        check_output("beq_nt_pc_sel", 32'(o_pc_sel), 32'd0);
        check_output("beq_nt_flush", 32'(o_flush), 32'd0);
        apply_stimulus(1, OPC_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 0);
        check_output("jal_pc_sel", 32'(o_pc_sel), 32'd1);
        apply_stimulus(1, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        apply_stimulus(1, OPC_JALR, 3'd0, 7'd0, 5'd1, 5'd0, 5'd1, 0);
        check_output("jalr_pc_sel", 32'(o_pc_sel), 32'd2);
        check_output("jalr_flush", 32'(o_flush), 32'd1);
        apply_stimulus(1, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);

        // Full divide: count stall cycles and launch pulses.
        stalls = 0;
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(1, OPC_OP, 3'd4, 7'b0000001, 5'd1, 5'd2, 5'd7, 0);
            if (o_div_start) starts++;
            if (!o_stall) break;
            stalls++;
        end
        check_output("div_stall_cycles", 32'(stalls), 32'(DIV_CYCLES));
        check_output("div_start_pulses", 32'(starts), 32'd1);
        apply_stimulus(1, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        check_output("div_wb_we", 32'(o_wb_we), 32'd1);
        check_output("div_wb_rd", 32'(o_wb_rd), 32'd7);

        // Second divide aborted by reset when ten wait cycles remain.
        apply_stimulus(1, OPC_OP, 3'd6, 7'b0000001, 5'd3, 5'd4, 5'd9, 0);
        for (int i = 0; i < 40 && m_done < DIV_CYCLES - 10; i++) begin
            apply_stimulus(1, OPC_OP, 3'd6, 7'b0000001, 5'd3, 5'd4, 5'd9, 0);
        end
        check_output("abort_in_wait", 32'(o_div_busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", 32'(div_busy), 32'd0);
        check_output("abort_stall", 32'(stall), 32'd0);
        check_output("abort_wb_we", 32'(wb_we), 32'd0);
        check_output("abort_ex_valid", 32'(ex_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, OPC_OP, 3'd6, 7'b0000001, 5'd3, 5'd4, 5'd9, 0);
            check_output("post_abort_start", 32'(o_div_start), 32'd0);
            check_output("post_abort_wb_we", 32'(o_wb_we), 32'd0);
        end

        // Randomized traffic; EX fields hold while the pipeline is stalled.
        for (int i = 0; i < 400; i++) begin
            if (!m_last_stall) gen_random();
            apply_stimulus($urandom_range(0, 3) != 0, r_op, r_f3, r_f7, r_rs1, r_rs2, r_rd, r_br);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
